regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_scoreboard.sv | 67 ++++++
 rtl/regfile_mp.sv | 114 +++++++++++
 tb/tb_regfile_mp.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
//------------------------------------------------------------------------------
// regfile_pkg: shared defaults, address-width helper and FSM state type
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;

   function automatic int addr_width(input int nreg);
      return (nreg > 1) ? $clog2(nreg) : 1;
   endfunction

   localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;
   localparam int                  ZERO_REG  = 0;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } rf_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
//------------------------------------------------------------------------------
// regfile_scoreboard: per-register pending-producer bits with claim/write priority
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NREG = NREG_DEF,
   parameter  int NRP  = 2,
   parameter  int NWP  = 2,
   localparam int AW   = addr_width(NREG)
) (
   input  logic              clk,
   input  logic              i_sweep,
   input  logic [AW-1:0]     i_sweep_idx,
   input  logic              i_run,
   input  logic              i_claim_en,
   input  logic [AW-1:0]     i_claim_addr,
   input  logic [NWP-1:0]    i_wr_en,
   input  logic [NWP*AW-1:0] i_wr_addr,
   input  logic [NRP*AW-1:0] i_rd_addr,
   output logic [NRP-1:0]    o_rd_busy
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   // Claims are applied after write clears so a same-cycle claim wins.
   always_comb begin
      busy_d = busy_q;
      if (i_sweep) begin
         busy_d[i_sweep_idx] = 1'b0;
      end else if (i_run) begin
         for (int k = 0; k < NWP; k++) begin
            if (i_wr_en[k] && (i_wr_addr[k*AW +: AW] != AW'(ZERO_REG))) begin
               busy_d[i_wr_addr[k*AW +: AW]] = 1'b0;
            end
         end
         if (i_claim_en && (i_claim_addr != AW'(ZERO_REG))) begin
            busy_d[i_claim_addr] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      busy_q <= busy_d;
   end

   always_comb begin
      o_rd_busy = '0;
      for (int p = 0; p < NRP; p++) begin
         if (i_run && (i_rd_addr[p*AW +: AW] != AW'(ZERO_REG))) begin
            o_rd_busy[p] = busy_q[i_rd_addr[p*AW +: AW]];
            for (int k = 0; k < NWP; k++) begin
               if (i_wr_en[k] && (i_wr_addr[k*AW +: AW] == i_rd_addr[p*AW +: AW])) begin
                  o_rd_busy[p] = 1'b0;
               end
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
//------------------------------------------------------------------------------
// regfile_mp: multi-port register file with clear sweep, write bypass, scoreboard
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int XLEN = XLEN_DEF,
   parameter  int NREG = NREG_DEF,
   parameter  int NRP  = 2,
   parameter  int NWP  = 2,
   localparam int AW   = addr_width(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NWP-1:0]      wr_en,
   input  logic [NWP*AW-1:0]   wr_addr,
   input  logic [NWP*XLEN-1:0] wr_data,
   input  logic [NRP*AW-1:0]   rd_addr,
   output logic [NRP*XLEN-1:0] rd_data,
   output logic [NRP-1:0]      rd_busy,
   input  logic                claim_en,
   input  logic [AW-1:0]       claim_addr,
   output logic                ready
);

   rf_state_e       state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] mem_q [NREG];
   logic [XLEN-1:0] mem_d [NREG];
   logic            w_sweep;
   logic            w_run;

   always_ff @(posedge clk) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (rst) begin
         state_d = ST_CLEAR;
         cnt_d   = '0;
      end else if (state_q == ST_CLEAR) begin
         cnt_d = cnt_q + AW'(1);
         if (cnt_q == AW'(NREG - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      end
   end

   // Gating with rst discards any write or claim presented alongside it.
   always_comb begin
      w_sweep = (state_q == ST_CLEAR) && !rst;
      w_run   = (state_q == ST_RUN) && !rst;
      ready   = w_run;
   end

   // Later ports overwrite earlier ones, giving the highest index priority.
   always_comb begin
      mem_d = mem_q;
      if (w_sweep) begin
         mem_d[cnt_q] = XLEN'(ZERO_WORD);
      end else if (w_run) begin
         for (int k = 0; k < NWP; k++) begin
            if (wr_en[k] && (wr_addr[k*AW +: AW] != AW'(ZERO_REG))) begin
               mem_d[wr_addr[k*AW +: AW]] = wr_data[k*XLEN +: XLEN];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      rd_data = '0;
      for (int p = 0; p < NRP; p++) begin
         if (w_run && (rd_addr[p*AW +: AW] != AW'(ZERO_REG))) begin
            rd_data[p*XLEN +: XLEN] = mem_q[rd_addr[p*AW +: AW]];
            for (int k = 0; k < NWP; k++) begin
               if (wr_en[k] && (wr_addr[k*AW +: AW] == rd_addr[p*AW +: AW])) begin
                  rd_data[p*XLEN +: XLEN] = wr_data[k*XLEN +: XLEN];
               end
            end
         end
      end
   end

   regfile_scoreboard #(
      .NREG (NREG),
      .NRP  (NRP),
      .NWP  (NWP)
   ) u_scoreboard (
      .clk          (clk),
      .i_sweep      (w_sweep),
      .i_sweep_idx  (cnt_q),
      .i_run        (w_run),
      .i_claim_en   (claim_en),
      .i_claim_addr (claim_addr),
      .i_wr_en      (wr_en),
      .i_wr_addr    (wr_addr),
      .i_rd_addr    (rd_addr),
      .o_rd_busy    (rd_busy)
   );

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
//------------------------------------------------------------------------------
// tb_regfile_mp: directed and randomized checks of regfile_mp against a reference model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_mp;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRP  = 2;
   localparam int NWP  = 2;
   localparam int AW   = 5;

   logic                clk;
   logic                rst;
   logic [NWP-1:0]      wr_en;
   logic [NWP*AW-1:0]   wr_addr;
   logic [NWP*XLEN-1:0] wr_data;
   logic [NRP*AW-1:0]   rd_addr;
   logic [NRP*XLEN-1:0] rd_data;
   logic [NRP-1:0]      rd_busy;
   logic                claim_en;
   logic [AW-1:0]       claim_addr;
   logic                ready;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: architectural register values, pending bits, sweep cycles left.
   logic [XLEN-1:0] m_mem  [NREG];
   logic            m_busy [NREG];
   int              m_clear_left = NREG;

   regfile_mp #(
      .XLEN (XLEN),
      .NREG (NREG),
      .NRP  (NRP),
      .NWP  (NWP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_busy    (rd_busy),
      .claim_en   (claim_en),
      .claim_addr (claim_addr),
      .ready      (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic m_run();
      return (m_clear_left == 0) && !rst;
   endfunction

   function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
      logic [XLEN-1:0] v;
      if (!m_run() || a == 0) return '0;
      v = m_mem[a];
      for (int k = 0; k < NWP; k++)
         if (wr_en[k] && wr_addr[k*AW +: AW] == a) v = wr_data[k*XLEN +: XLEN];
      return v;
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      logic b;
      if (!m_run() || a == 0) return 1'b0;
      b = m_busy[a];
      for (int k = 0; k < NWP; k++)
         if (wr_en[k] && wr_addr[k*AW +: AW] == a) b = 1'b0;
      return b;
   endfunction

   task automatic idle();
      rst        = 1'b0;
      wr_en      = '0;
      wr_addr    = '0;
      wr_data    = '0;
      rd_addr    = '0;
      claim_en   = 1'b0;
      claim_addr = '0;
   endtask

   task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      wr_en[k]                = 1'b1;
      wr_addr[k*AW +: AW]     = a;
      wr_data[k*XLEN +: XLEN] = d;
   endtask

   task automatic set_rd(input int p, input logic [AW-1:0] a);
      rd_addr[p*AW +: AW] = a;
   endtask

   // Advances one clock edge, applying the architectural rules to the model.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_clear_left = NREG;
      end else if (m_clear_left > 0) begin
         m_clear_left--;
         if (m_clear_left == 0)
            for (int i = 0; i < NREG; i++) begin
               m_mem[i]  = '0;
               m_busy[i] = 1'b0;
            end
      end else begin
         for (int k = 0; k < NWP; k++)
            if (wr_en[k] && wr_addr[k*AW +: AW] != 0) begin
               m_mem[wr_addr[k*AW +: AW]]  = wr_data[k*XLEN +: XLEN];
               m_busy[wr_addr[k*AW +: AW]] = 1'b0;
            end
         if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1'b1;
      end
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      int cycles;
      idle();
      rst = 1'b1;
      #1;
      n_checks++;
      if (ready !== 1'b0 || rd_data !== '0 || rd_busy !== '0) begin
         n_fail++;
         $display("FAIL reset_hold: ready=%b rd_data=%h rd_busy=%b, required 0/0/0", ready, rd_data, rd_busy);
      end
      tick();
      rst = 1'b0;
      cycles = 0;
      while (ready !== 1'b1 && cycles < 100) begin
         n_checks++;
         if (rd_data !== '0 || rd_busy !== '0) begin
            n_fail++;
            $display("FAIL clear_outputs: rd_data=%h rd_busy=%b, required 0", rd_data, rd_busy);
         end
         tick();
         cycles++;
      end
      n_checks++;
      if (cycles !== NREG) begin
         n_fail++;
         $display("FAIL clear_length: ready after %0d cycles, required %0d", cycles, NREG);
      end
      for (int a = 0; a < NREG; a++) begin
         set_rd(0, AW'(a));
         set_rd(1, AW'(NREG - 1 - a));
         #1;
         n_checks++;
         if (rd_data !== '0 || rd_busy !== '0) begin
            n_fail++;
            $display("FAIL swept_read x%0d: rd_data=%h rd_busy=%b, required 0", a, rd_data, rd_busy);
         end
         tick();
      end
   endtask

   task automatic test_same_addr_write();
      idle();
      set_wr(0, 5'd5, 32'h1234_5678);
      set_wr(1, 5'd5, 32'hDEAD_BEEF);
      set_rd(0, 5'd5);
      #1;
      n_checks++;
      if (rd_data[0 +: XLEN] !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL bypass_priority: got %h, required deadbeef", rd_data[0 +: XLEN]);
      end
      tick();
      idle();
      set_rd(0, 5'd5);
      #1;
      n_checks++;
      if (rd_data[0 +: XLEN] !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL write_priority: got %h, required deadbeef", rd_data[0 +: XLEN]);
      end
      tick();
   endtask

   task automatic test_x0();
      idle();
      set_wr(1, 5'd0, 32'hFFFF_FFFF);
      claim_en   = 1'b1;
      claim_addr = 5'd0;
      set_rd(0, 5'd0);
      #1;
      n_checks++;
      if (rd_data[0 +: XLEN] !== 32'h0 || rd_busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL x0_same_cycle: got %h busy %b, required 0 busy 0", rd_data[0 +: XLEN], rd_busy[0]);
      end
      tick();
      idle();
      set_rd(1, 5'd0);
      #1;
      n_checks++;
      if (rd_data[XLEN +: XLEN] !== 32'h0 || rd_busy[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL x0_after: got %h busy %b, required 0 busy 0", rd_data[XLEN +: XLEN], rd_busy[1]);
      end
      tick();
   endtask

   task automatic test_claim_then_write();
      idle();
      claim_en   = 1'b1;
      claim_addr = 5'd7;
      tick();
      idle();
      set_rd(0, 5'd7);
      #1;
      n_checks++;
      if (rd_busy[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL claim_sets_busy: busy %b, required 1", rd_busy[0]);
      end
      tick();
      set_wr(0, 5'd7, 32'h0000_00A5);
      #1;
      n_checks++;
      if (rd_busy[0] !== 1'b0 || rd_data[0 +: XLEN] !== 32'hA5) begin
         n_fail++;
         $display("FAIL write_bypass_busy: got %h busy %b, required a5 busy 0", rd_data[0 +: XLEN], rd_busy[0]);
      end
      tick();
      idle();
      set_rd(0, 5'd7);
      #1;
      n_checks++;
      if (rd_busy[0] !== 1'b0 || rd_data[0 +: XLEN] !== 32'hA5) begin
         n_fail++;
         $display("FAIL write_clears_busy: got %h busy %b, required a5 busy 0", rd_data[0 +: XLEN], rd_busy[0]);
      end
      tick();
   endtask

   task automatic test_claim_and_write();
      idle();
      claim_en   = 1'b1;
      claim_addr = 5'd9;
      set_wr(1, 5'd9, 32'h0000_0042);
      tick();
      idle();
      set_rd(1, 5'd9);
      #1;
      n_checks++;
      if (rd_data[XLEN +: XLEN] !== 32'h42 || rd_busy[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL claim_wins: got %h busy %b, required 42 busy 1", rd_data[XLEN +: XLEN], rd_busy[1]);
      end
      tick();
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      for (int cyc = 0; cyc < 600; cyc++) begin
         idle();
         rst = ($urandom_range(0, 249) == 0);
         for (int k = 0; k < NWP; k++)
            if ($urandom_range(0, 1) == 1)
               set_wr(k, AW'($urandom_range(0, 7)), $urandom);
         claim_en   = ($urandom_range(0, 2) == 0);
         claim_addr = AW'($urandom_range(0, 7));
         for (int p = 0; p < NRP; p++)
            if ($urandom_range(0, 1) == 1) set_rd(p, wr_addr[($urandom_range(0, NWP - 1))*AW +: AW]);
            else set_rd(p, AW'($urandom_range(0, NREG - 1)));
         #1;
         n_checks++;
         if (ready !== m_run()) begin
            n_fail++;
            $display("FAIL rand_ready cyc %0d: got %b, required %b", cyc, ready, m_run());
         end
         for (int p = 0; p < NRP; p++) begin
            a = rd_addr[p*AW +: AW];
            n_checks++;
            if (rd_data[p*XLEN +: XLEN] !== exp_rd(a) || rd_busy[p] !== exp_busy(a)) begin
               n_fail++;
               $display("FAIL rand_read cyc %0d port %0d x%0d: got %h busy %b, required %h busy %b",
                        cyc, p, a, rd_data[p*XLEN +: XLEN], rd_busy[p], exp_rd(a), exp_busy(a));
            end
         end
         tick();
      end
      idle();
      for (int i = 0; i < NREG + 2; i++) tick();
   endtask

   task automatic test_reset_mid_clear();
      int cycles;
      idle();
      set_wr(0, 5'd3, 32'h0000_0055);
      tick();
      idle();
      set_rd(0, 5'd3);
      #1;
      n_checks++;
      if (rd_data[0 +: XLEN] !== 32'h55) begin
         n_fail++;
         $display("FAIL pre_reset_write: got %h, required 55", rd_data[0 +: XLEN]);
      end
      rst = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         idle();
         wr_en      = 2'b11;
         wr_addr    = {5'd3, 5'd3};
         wr_data    = {32'hCAFE_0001, 32'hCAFE_0002};
         claim_en   = 1'b1;
         claim_addr = 5'd3;
         set_rd(0, 5'd3);
         set_rd(1, 5'd4);
         #1;
         n_checks++;
         if (ready !== 1'b0 || rd_data !== '0 || rd_busy !== '0) begin
            n_fail++;
            $display("FAIL clear_ignores_io: ready=%b rd_data=%h rd_busy=%b, required 0/0/0", ready, rd_data, rd_busy);
         end
         tick();
      end
      idle();
      rst = 1'b1;
      set_wr(1, 5'd3, 32'h0000_0099);
      tick();
      idle();
      cycles = 0;
      while (ready !== 1'b1 && cycles < 100) begin
         tick();
         cycles++;
      end
      n_checks++;
      if (cycles !== NREG) begin
         n_fail++;
         $display("FAIL restart_length: ready after %0d cycles, required %0d", cycles, NREG);
      end
      set_rd(0, 5'd3);
      #1;
      n_checks++;
      if (rd_data[0 +: XLEN] !== 32'h0 || rd_busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_swept: got %h busy %b, required 0 busy 0", rd_data[0 +: XLEN], rd_busy[0]);
      end
      tick();
   endtask

   initial begin
      idle();
      @(negedge clk);
      #1;
      test_reset();
      test_same_addr_write();
      test_x0();
      test_claim_then_write();
      test_claim_and_write();
      test_random();
      test_reset_mid_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
